inv_mix_columns_seq: RTL and testbench
======================================

Name: inv_mix_columns_seq

Overview:
Iterative AES InvMixColumns engine for the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and multiplies each 32-bit column by the inverse matrix [0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e] in GF(2^8), using poly 0x11B. It processes COLS_PER_CYCLE columns per clock, then holds the result until the downstream stage accepts it.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4. Any other value is an elaboration error.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_state is valid
in_ready  output  1  engine can accept a new state
in_state  input  128  state to transform; column c = bits [127-32c -: 32], row 0 byte = MSB of each column
out_valid  output  1  out_state holds a completed result
out_ready  input  1  downstream accepts out_state
out_state  output  128  InvMixColumns(in_state), same byte layout
busy  output  1  high while columns are being computed

Behaviour:
- Reset (async, while rst=1): FSM=IDLE, working register=0, column counter=0, out_valid=0, out_state=0, busy=0. in_ready=1 after reset deasserts.
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, capture in_state into the working register, clear the counter and go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle, replace columns [cnt .. cnt+COLS_PER_CYCLE-1] in place with their inverse-mixed values, then add COLS_PER_CYCLE to cnt. Columns are processed in order from col 0 (bits 127:96) to col 3. After the cycle that writes col 3, load out_state, set out_valid=1 and go to DONE.
  - DONE: out_valid=1, out_state stable. When out_ready=1, the handshake completes and out_valid falls next cycle.
- Back-to-back: in DONE, in_ready = out_ready. If in_valid and out_ready are both high in the same cycle, the result is retired and the new state captured; go straight to BUSY with out_valid=0 next cycle.
- If out_ready=1 in DONE without in_valid, go to IDLE.
- Latency:
  - Accept edge to out_valid = 4/COLS_PER_CYCLE + 1 cycles: 5, 3 or 2.
  - Throughput with out_ready tied high: one block every 4/COLS_PER_CYCLE + 1 cycles.
- Column arithmetic, for bytes a0..a3 (a0 = row 0):
  - Build xt(x) = (x<<1) ^ (x[7] ? 0x1B : 0), with x4 = xt(xt(x)) and x8 = xt(x4).
  - 09·x = x8^x; 0b·x = x8^xt(x)^x; 0d·x = x8^x4^x; 0e·x = x8^x4^xt(x).
  - All arithmetic is 8-bit; no carries beyond bit 7.
- in_state, in_valid and out_ready are sampled only as specified; in_state changes while BUSY are ignored.
- out_state changes only on entry to DONE and on reset. It is never updated while out_valid=1 and out_ready=0.
- Reset mid-operation (BUSY or DONE): the in-flight block is discarded and all outputs return to reset values immediately (async).
- in_valid asserted during reset is ignored; capture happens only on a clock edge with rst=0.

Decomposition:
- Shared package aes_pkg:
  - AES_POLY_LSB = 8'h1B
  - typedefs byte_t (8-bit), col_t (32-bit), state_t (128-bit)
  - FSM enum {IDLE, BUSY, DONE}
  - function xtime
- One natural sub-module: inv_mix_column (purely combinational, col_t in → col_t out). Instantiate it COLS_PER_CYCLE times; the FSM, counter and holding register stay in the top.

Test Plan:
- FIPS-197 vector, COLS_PER_CYCLE=1, out_ready=1: in_state=046681e5e0cb199a48f8d37a2806264c → out_state=d4bf5d30e0b452aeb84111f11e2798e5. out_valid rises exactly 5 cycles after the accept edge and stays high for 1 cycle.
- Column vectors (all widths 1/2/4): the columns are 8e4da1bc, 9fdc589d, d5d5d7d6 and 01010101. Expected: in=8e4da1bc9fdc589dd5d5d7d601010101 → out=db135345f20a225cd4d4d4d501010101. Latency must be 5, 3 and 2 cycles respectively.
- Backpressure: out_ready=0 for 10 cycles after out_valid. out_state and out_valid must stay constant and in_ready must stay 0. On out_ready=1 for one cycle, out_valid falls and in_ready=1.
- Back-to-back: hold in_valid=1 and out_ready=1 with three distinct states. Expect no idle cycle between blocks, one result every 5 cycles (COLS_PER_CYCLE=1), correct order, and no dropped or duplicated blocks.
- Reset mid-BUSY: assert rst 2 cycles after accept. Expect out_valid=0, out_state=0 and busy=0 asynchronously, before the next clk edge. After release, a new FIPS-197 vector yields the correct result.
- Round-trip: apply 1000 random states first through the forward MixColumns and then through this block. Expect output == original for every state; no in_state changes while BUSY may corrupt the output.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and the GF(2^8) doubling helper used by the
// InvMixColumns datapath.
package aes_pkg;

    localparam logic [7:0]  AES_POLY_LSB = 8'h1B;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned COL_W        = 32;
    localparam int unsigned STATE_W      = 128;

    typedef logic [BYTE_W-1:0]  byte_t;
    typedef logic [COL_W-1:0]   col_t;
    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_LSB : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns for one 32-bit column (row 0 in the MSB byte).
module inv_mix_column
    import aes_pkg::*;
(
    input  col_t col_i,
    output col_t col_o
);

    byte_t a  [4];
    byte_t x2 [4];
    byte_t x4 [4];
    byte_t x8 [4];
    byte_t m9 [4];
    byte_t mb [4];
    byte_t md [4];
    byte_t me [4];

    // Build the 09/0b/0d/0e multiples of every input byte from repeated doubling.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a[r]  = col_i[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
    end

    assign col_o = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns engine: captures a state, mixes COLS_PER_CYCLE
// columns per clock in place, then holds the result until it is accepted.
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned NUM_COLS = 4;
    localparam logic [1:0]  LAST_CNT = 2'(NUM_COLS - COLS_PER_CYCLE);
    localparam logic [1:0]  CNT_STEP = 2'(COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    fsm_e                  state_q;
    logic [3:0][COL_W-1:0] work_q;
    logic [3:0][COL_W-1:0] work_d;
    logic [1:0]            cnt_q;
    logic                  out_valid_q;
    state_t                out_state_q;

    logic [1:0] sel     [COLS_PER_CYCLE];
    col_t       col_in  [COLS_PER_CYCLE];
    col_t       col_out [COLS_PER_CYCLE];

    // Column c lives in packed slot 3-c, so col 0 is the MSB word.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign sel[g]    = 2'(NUM_COLS - 1) - cnt_q - 2'(g);
        assign col_in[g] = work_q[sel[g]];

        inv_mix_column u_inv_mix_column (
            .col_i (col_in[g]),
            .col_o (col_out[g])
        );
    end

    always_comb begin
        work_d = work_q;
        for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
            work_d[sel[k]] = col_out[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_state;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + CNT_STEP;
                    // The final slice lands straight in the holding register.
                    if (cnt_q == LAST_CNT) begin
                        out_state_q <= work_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            work_q  <= in_state;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A finished block frees the input port in the same cycle it is retired.
    assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign busy      = (state_q == BUSY);
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: three instances (1, 2 and 4 columns per
// cycle) checked against a matrix-multiply GF(2^8) reference model.
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         iv   [3];
    logic         ir   [3];
    logic [127:0] ist  [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [127:0] ost  [3];
    logic         bz   [3];

    int total;
    int bad;

    localparam logic [127:0] FIPS_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] COLS_IN  = 128'h8e4da1bc9fdc589dd5d5d7d601010101;
    localparam logic [127:0] COLS_OUT = 128'hdb135345f20a225cd4d4d4d501010101;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_state  (ist[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_state (ost[g]),
            .busy      (bz[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full polynomial product, then reduction by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (15'h11B << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mat_mul(input logic [127:0] s, input bit inverse);
        logic [7:0]   m [16];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inverse) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09, 8'h09, 8'h0e, 8'h0b, 8'h0d,
                           8'h0d, 8'h09, 8'h0e, 8'h0b, 8'h0b, 8'h0d, 8'h09, 8'h0e};
        else         m = '{8'h02, 8'h03, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01,
                           8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h01, 8'h01, 8'h02};
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(m[row*4+j], s[127-32*c-8*j -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one state to instance i and wait for its result; lat counts edges
    // from the accept edge through the edge that raises out_valid.
    task automatic send(input int i, input logic [127:0] st,
                        output logic [127:0] res, output int lat, output bit to);
        int n;
        bit acc;
        to = 1'b0; lat = 0; res = '0; n = 0;
        ordy[i] = 1'b1; iv[i] = 1'b1; ist[i] = st;
        do begin
            acc = ir[i];
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        iv[i] = 1'b0;
        if (!acc) begin
            to = 1'b1;
            return;
        end
        lat = 1;
        ist[i] = rnd128();
        while (!ov[i] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            ist[i] = rnd128();
        end
        if (!ov[i]) to = 1'b1;
        res = ost[i];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ov[i] !== 1'b0 || ost[i] !== 128'h0 || bz[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got ov=%b st=%h busy=%b want 0/0/0", i, ov[i], ost[i], bz[i]);
            end
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || bz[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_release[%0d]: got in_ready=%b ov=%b busy=%b want 1/0/0", i, ir[i], ov[i], bz[i]);
            end
        end
    endtask

    task automatic test_fips();
        logic [127:0] res;
        int lat;
        bit to;
        send(0, FIPS_IN, res, lat, to);
        total++;
        if (to || res !== FIPS_OUT) begin
            bad++;
            $display("FAIL fips_result: got %h (timeout=%0b) want %h", res, to, FIPS_OUT);
        end
        total++;
        if (lat !== 5) begin
            bad++;
            $display("FAIL fips_latency: got %0d want 5", lat);
        end
        total++;
        if (ov[0] !== 1'b0) begin
            bad++;
            $display("FAIL fips_valid_one_cycle: got out_valid=%b want 0", ov[0]);
        end
    endtask

    task automatic test_widths();
        logic [127:0] res;
        int lat;
        bit to;
        for (int i = 0; i < 3; i++) begin
            send(i, COLS_IN, res, lat, to);
            total++;
            if (to || res !== COLS_OUT) begin
                bad++;
                $display("FAIL width_result[cpc=%0d]: got %h want %h", 1 << i, res, COLS_OUT);
            end
            total++;
            if (lat !== 4 / (1 << i) + 1) begin
                bad++;
                $display("FAIL width_latency[cpc=%0d]: got %0d want %0d", 1 << i, lat, 4 / (1 << i) + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] s;
        logic [127:0] held;
        int n;
        bit acc;
        s = rnd128();
        ordy[0] = 1'b0; iv[0] = 1'b1; ist[0] = s; n = 0;
        do begin
            acc = ir[0];
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        held = ost[0];
        total++;
        if (!ov[0] || held !== mat_mul(s, 1'b1)) begin
            bad++;
            $display("FAIL bp_result: got ov=%b st=%h want 1/%h", ov[0], held, mat_mul(s, 1'b1));
        end
        for (int c = 0; c < 10; c++) begin
            ist[0] = rnd128(); iv[0] = c[0];
            @(posedge clk); #1;
            total++;
            if (ov[0] !== 1'b1 || ost[0] !== held || ir[0] !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got ov=%b st=%h in_ready=%b want 1/%h/0", c, ov[0], ost[0], ir[0], held);
            end
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got ov=%b in_ready=%b want 0/1", ov[0], ir[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] sent [3];
        logic [127:0] outs [$];
        int acc_cyc [$];
        int out_cyc [$];
        int k;
        int cyc;
        bit acc;
        for (int j = 0; j < 3; j++) sent[j] = rnd128();
        k = 0; cyc = 0;
        ordy[0] = 1'b1; iv[0] = 1'b1; ist[0] = sent[0];
        while (outs.size() < 3 && cyc < 100) begin
            acc = iv[0] && ir[0];
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                acc_cyc.push_back(cyc);
                k++;
                if (k < 3) ist[0] = sent[k];
                else begin
                    iv[0] = 1'b0;
                    ist[0] = rnd128();
                end
            end
            if (ov[0]) begin
                outs.push_back(ost[0]);
                out_cyc.push_back(cyc);
            end
        end
        iv[0] = 1'b0;
        @(posedge clk); #1;
        total++;
        if (outs.size() != 3 || acc_cyc.size() != 3) begin
            bad++;
            $display("FAIL b2b_count: got results=%0d accepts=%0d want 3/3", outs.size(), acc_cyc.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                total++;
                if (outs[j] !== mat_mul(sent[j], 1'b1)) begin
                    bad++;
                    $display("FAIL b2b_result[%0d]: got %h want %h", j, outs[j], mat_mul(sent[j], 1'b1));
                end
            end
            total++;
            if (out_cyc[0] - acc_cyc[0] != 4) begin
                bad++;
                $display("FAIL b2b_first_latency: got %0d edges want 4", out_cyc[0] - acc_cyc[0]);
            end
            for (int j = 1; j < 3; j++) begin
                total++;
                if (out_cyc[j] - out_cyc[j-1] != 5 || acc_cyc[j] - acc_cyc[j-1] != 5) begin
                    bad++;
                    $display("FAIL b2b_spacing[%0d]: got out=%0d acc=%0d want 5/5", j,
                             out_cyc[j] - out_cyc[j-1], acc_cyc[j] - acc_cyc[j-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] res;
        int lat;
        int n;
        bit to;
        bit acc;
        ordy[0] = 1'b1; iv[0] = 1'b1; ist[0] = FIPS_IN; n = 0;
        do begin
            acc = ir[0];
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        iv[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (bz[0] !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre_busy: got busy=%b want 1", bz[0]);
        end
        rst = 1'b1;
        #1;
        total++;
        if (ov[0] !== 1'b0 || ost[0] !== 128'h0 || bz[0] !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_async: got ov=%b st=%h busy=%b want 0/0/0", ov[0], ost[0], bz[0]);
        end
        iv[0] = 1'b1;
        @(negedge clk); rst = 1'b0; iv[0] = 1'b0;
        @(posedge clk); #1;
        send(0, FIPS_IN, res, lat, to);
        total++;
        if (to || res !== FIPS_OUT || lat !== 5) begin
            bad++;
            $display("FAIL rst_mid_recover: got %h lat=%0d want %h lat=5", res, lat, FIPS_OUT);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] orig;
        logic [127:0] res;
        int lat;
        bit to;
        for (int n = 0; n < 1000; n++) begin
            orig = rnd128();
            send(n % 3, mat_mul(orig, 1'b0), res, lat, to);
            total++;
            if (to || res !== orig) begin
                bad++;
                $display("FAIL round_trip[%0d cpc=%0d]: got %h want %h", n, 1 << (n % 3), res, orig);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ist[i]  = '0;
            ordy[i] = 1'b1;
        end
        test_reset();
        test_fips();
        test_widths();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
